// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   state_t         : controller FSM states (IDLE, REQ)
//   CMD_*           : command register encodings (EOI / specific EOI)
//   DEF_VECTOR_BASE : default vector number for line 0
//   lowest_idx()    : index of the lowest set bit (0 when none set)
package irq_pkg;

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [7:0] CMD_EOI         = 8'h20;
    localparam logic [7:0] CMD_SEOI_MASK   = 8'hF8;
    localparam logic [7:0] CMD_SEOI        = 8'h60;
    localparam logic [7:0] DEF_VECTOR_BASE = 8'h08;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (v[i-1]) idx = 3'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge.sv
// One interrupt line: 2-FF synchronizer followed by a registered
// rising-edge detector.
//   clock   : system clock
//   reset_n : asynchronous active-low reset, clears every flop
//   d       : asynchronous input line
//   rise    : one-clock pulse after a synchronized 0->1 transition
module irq_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic s1, s2, s3;

    // All flops reset to 0, so a line already high at reset release
    // is seen as a rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// 8-line priority interrupt controller (IRR/IMR/ISR) with vectored
// request/acknowledge handshake to the core.
//   clock, reset_n : system clock, asynchronous active-low reset
//   irq_in         : asynchronous rising-edge interrupt lines
//   io_addr/we/wdata : register writes (0 = command, 1 = IMR)
//   io_rdata       : registered read data (0 = IRR, 1 = IMR)
//   intr_ack       : core accepted the presented vector
//   intr, irq      : interrupt request and vector number to the core
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE = DEF_VECTOR_BASE
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] irq_in,
    input  logic       io_addr,
    input  logic       io_we,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    input  logic       intr_ack,
    output logic       intr,
    output logic [7:0] irq
);

    state_t     state, state_next;
    logic [7:0] irr, irr_next;
    logic [7:0] isr, isr_next;
    logic [7:0] imr;
    logic [2:0] cur, cur_next;
    logic [7:0] irq_next;
    logic [7:0] edges;
    logic [7:0] eligible, le_mask, ack_set, eoi_clr;
    logic [2:0] cand;
    logic       serviceable;

    for (genvar g = 0; g < 8; g++) begin : g_line
        irq_edge u_edge (
            .clock   (clock),
            .reset_n (reset_n),
            .d       (irq_in[g]),
            .rise    (edges[g])
        );
    end

    assign intr = (state == REQ);

    always_comb begin
        eligible    = irr & ~imr;
        cand        = lowest_idx(eligible);
        le_mask     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            le_mask[i] = (i <= 32'(cand));
        end
        // Only the top-priority candidate matters: a higher index is
        // blocked by any ISR bit that blocks the lower one.
        serviceable = (|eligible) && ((isr & le_mask) == '0);

        state_next = state;
        cur_next   = cur;
        irq_next   = irq;
        ack_set    = '0;
        case (state)
            IDLE: begin
                if (serviceable) begin
                    state_next = REQ;
                    cur_next   = cand;
                    irq_next   = VECTOR_BASE + {5'b0, cand};
                end
            end
            REQ: begin
                if (intr_ack) begin
                    state_next = IDLE;
                    ack_set    = 8'h01 << cur;
                end
            end
            default: state_next = IDLE;
        endcase

        // EOI decodes against the pre-ack ISR; ack set is OR'd after.
        eoi_clr = '0;
        if (io_we && !io_addr) begin
            if (io_wdata == CMD_EOI) begin
                if (|isr) eoi_clr = 8'h01 << lowest_idx(isr);
            end else if ((io_wdata & CMD_SEOI_MASK) == CMD_SEOI) begin
                eoi_clr = 8'h01 << io_wdata[2:0];
            end
        end

        // A new edge wins over the ack clear on the same line.
        irr_next = (irr & ~ack_set) | edges;
        isr_next = (isr & ~eoi_clr) | ack_set;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur      <= '0;
            irq      <= '0;
            irr      <= '0;
            isr      <= '0;
            imr      <= '1;
            io_rdata <= '0;
        end else begin
            state    <= state_next;
            cur      <= cur_next;
            irq      <= irq_next;
            irr      <= irr_next;
            isr      <= isr_next;
            if (io_we && io_addr) imr <= io_wdata;
            io_rdata <= io_addr ? imr : irr;
        end
    end

endmodule
